// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for a 5-stage RISC-V pipeline with boot purge and memory-wait FSM.
// Optional macro PERF_CNT_EN adds saturating StallCnt/FlushCnt performance counters.
module pipeline_hazard_ctrl #(
    parameter int BOOT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemReqM,
    input  logic             MemAckM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             StallW,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemBusy,
    output logic             MemErr,
`ifdef PERF_CNT_EN
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt,
`endif
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int WW = $clog2(MEM_TIMEOUT);
    localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [BW-1:0] boot_cnt_q, boot_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_err_q, mem_err_d;
    logic          lw_stall, timeout, freeze;

    // MEM stage has the younger result, so it takes priority over WB.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rdm,
                                           input logic wm, input logic [4:0] rdw, input logic ww);
        if (wm && rdm != 5'd0 && rdm == rs)      return 2'b10;
        else if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
        else                                     return 2'b00;
    endfunction

    always_comb begin
        lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
        // The wait counter already holds 1 on entry, so the RUN cycle counts toward the timeout.
        timeout  = (state_q == MEM_WAIT) && !MemAckM && (wait_cnt_q == WAIT_LAST);
        freeze   = ((state_q == RUN) && MemReqM && !MemAckM) ||
                   ((state_q == MEM_WAIT) && !MemAckM && !timeout);

        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        StallW     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        ForwardAE  = 2'b00;
        ForwardBE  = 2'b00;
        MemBusy    = 1'b0;
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;

        case (state_q)
            BOOT: begin
                StallF = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d    = RUN;
                    boot_cnt_d = '0;
                end else begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                end
            end
            default: begin
                ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
                ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
                if (freeze) begin
                    {StallF, StallD, StallE, StallM, StallW} = 5'b11111;
                    MemBusy = 1'b1;
                    state_d = MEM_WAIT;
                    wait_cnt_d = (state_q == RUN) ? WW'(1) : wait_cnt_q + 1'b1;
                end else begin
                    if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (lw_stall) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    if (timeout) mem_err_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            boot_cnt_q <= '0;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign MemErr    = mem_err_q;
    assign dbg_state = state_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != BOOT && StallF && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
        if (state_q == RUN && FlushD && flush_cnt_q != '1)  flush_cnt_d = flush_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected outputs, a negedge monitor compares.
module tb_pipeline_hazard_ctrl;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_MW   = 2'd2;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, RegWriteM, RegWriteW, MemReqM, MemAckM;
    logic       StallF, StallD, StallE, StallM, StallW, FlushD, FlushE, MemBusy, MemErr;
    logic [1:0] ForwardAE, ForwardBE, dbg_state;
`ifdef PERF_CNT_EN
    logic [31:0] StallCnt, FlushCnt;
`endif

    logic [14:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    pipeline_hazard_ctrl #(.BOOT_CYCLES(4), .MEM_TIMEOUT(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemReqM(MemReqM), .MemAckM(MemAckM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM), .StallW(StallW),
        .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MemBusy(MemBusy), .MemErr(MemErr),
`ifdef PERF_CNT_EN
        .StallCnt(StallCnt), .FlushCnt(FlushCnt),
`endif
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] e(input logic [1:0] st, input logic [4:0] stl, input logic [1:0] fl,
                                      input logic [1:0] fa, input logic [1:0] fb,
                                      input logic busy, input logic err);
        return {st, stl, fl, fa, fb, busy, err};
    endfunction

    task automatic idle_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 2'b00; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0; MemReqM = 0; MemAckM = 0;
    endtask

    task automatic step(input logic [14:0] ex, input string nm);
        exp_q.push_back(ex);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are combinational, so each pushed cycle is checked mid-cycle.
    always @(negedge clk) begin
        logic [14:0] act, ex;
        string nm;
        if (exp_q.size() != 0) begin
            ex  = exp_q.pop_front();
            nm  = name_q.pop_front();
            act = {dbg_state, StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
                   ForwardAE, ForwardBE, MemBusy, MemErr};
            n_checks++;
            if (act !== ex) begin
                n_fail++;
                $display("FAIL %s: got st=%b stl=%b fl=%b fa=%b fb=%b busy=%b err=%b, expected st=%b stl=%b fl=%b fa=%b fb=%b busy=%b err=%b",
                         nm, act[14:13], act[12:8], act[7:6], act[5:4], act[3:2], act[1], act[0],
                         ex[14:13], ex[12:8], ex[7:6], ex[5:4], ex[3:2], ex[1], ex[0]);
            end
        end
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 4; i++) step(e(S_BOOT, 5'b10000, 2'b11, 2'b00, 2'b00, 0, 0), "boot");
        step(e(S_RUN, 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0), "run_idle");

        ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
        step(e(S_RUN, 5'b11000, 2'b01, 2'b00, 2'b00, 0, 0), "lw_rs1");
        Rs1D = 0; Rs2D = 5;
        step(e(S_RUN, 5'b11000, 2'b01, 2'b00, 2'b00, 0, 0), "lw_rs2");
        RdE = 0; Rs1D = 0; Rs2D = 0;
        step(e(S_RUN, 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0), "lw_rd0");
        ResultSrcE = 2'b00; RdE = 5; Rs1D = 5;
        step(e(S_RUN, 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0), "not_load");
        idle_inputs();

        RdM = 3; RdW = 3; RegWriteM = 1; RegWriteW = 1; Rs1E = 3; Rs2E = 0;
        step(e(S_RUN, 5'b00000, 2'b00, 2'b10, 2'b00, 0, 0), "fwd_mem_wins");
        RegWriteM = 0;
        step(e(S_RUN, 5'b00000, 2'b00, 2'b01, 2'b00, 0, 0), "fwd_wb");
        RdM = 0; RegWriteM = 1; Rs1E = 0; Rs2E = 0;
        step(e(S_RUN, 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0), "fwd_x0");
        RdM = 4; RdW = 7; Rs1E = 4; Rs2E = 7;
        step(e(S_RUN, 5'b00000, 2'b00, 2'b10, 2'b01, 0, 0), "fwd_split");
        idle_inputs();

        PCSrcE = 1;
        step(e(S_RUN, 5'b00000, 2'b11, 2'b00, 2'b00, 0, 0), "branch_flush");
        ResultSrcE = 2'b01; RdE = 9; Rs2D = 9;
        step(e(S_RUN, 5'b00000, 2'b11, 2'b00, 2'b00, 0, 0), "branch_beats_lw");
        ResultSrcE = 2'b00; RdE = 0; Rs2D = 0;
        MemReqM = 1; MemAckM = 0;
        step(e(S_RUN, 5'b11111, 2'b00, 2'b00, 2'b00, 1, 0), "freeze_beats_branch");
        PCSrcE = 0; MemReqM = 0; RdM = 3; RegWriteM = 1; Rs1E = 3;
        step(e(S_MW, 5'b11111, 2'b00, 2'b10, 2'b00, 1, 0), "wait_req_dropped");
        MemAckM = 1;
        step(e(S_MW, 5'b00000, 2'b00, 2'b10, 2'b00, 0, 0), "wait_ack");
        idle_inputs();
        step(e(S_RUN, 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0), "after_ack");

        MemReqM = 1; MemAckM = 1;
        step(e(S_RUN, 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0), "same_cycle_ack");
        MemAckM = 0;
        step(e(S_RUN, 5'b11111, 2'b00, 2'b00, 2'b00, 1, 0), "ack3_c1");
        step(e(S_MW, 5'b11111, 2'b00, 2'b00, 2'b00, 1, 0), "ack3_c2");
        step(e(S_MW, 5'b11111, 2'b00, 2'b00, 2'b00, 1, 0), "ack3_c3");
        MemAckM = 1;
        step(e(S_MW, 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0), "ack3_ack");
        idle_inputs();
        step(e(S_RUN, 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0), "ack3_run");

        MemReqM = 1;
        step(e(S_RUN, 5'b11111, 2'b00, 2'b00, 2'b00, 1, 0), "to_first");
        for (int i = 0; i < 62; i++) step(e(S_MW, 5'b11111, 2'b00, 2'b00, 2'b00, 1, 0), "to_wait");
        step(e(S_MW, 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0), "to_release");
        MemReqM = 0;
        step(e(S_RUN, 5'b00000, 2'b00, 2'b00, 2'b00, 0, 1), "err_set");
        PCSrcE = 1;
        step(e(S_RUN, 5'b00000, 2'b11, 2'b00, 2'b00, 0, 1), "err_sticky");
        PCSrcE = 0;

        MemReqM = 1;
        step(e(S_RUN, 5'b11111, 2'b00, 2'b00, 2'b00, 1, 1), "pre_rst_freeze");
        rst = 1;
        step(e(S_MW, 5'b11111, 2'b00, 2'b00, 2'b00, 1, 1), "rst_cycle");
        rst = 0; MemReqM = 0;
        for (int i = 0; i < 4; i++) step(e(S_BOOT, 5'b10000, 2'b11, 2'b00, 2'b00, 0, 0), "reboot");
        step(e(S_RUN, 5'b00000, 2'b00, 2'b00, 2'b00, 0, 0), "reboot_run");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
